cali_rls_seq: RTL

//   Sequencer for the piecewise LMS/RLS DTC-nonlinearity calibration datapath.
//   - Clears the LUTs, then sweeps all 8 sync_dly settings under LMS.
//   - Measures accumulated |ERR| per setting and selects the minimum.
//   - Converges coarsely in LMS, then hands over to RLS.
//   - Watches RLS for divergence and falls back to LMS if it diverges.

---
 rtl/cali_rls_seq.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cali_rls_seq.sv
// cali_rls_seq: sequencer for the piecewise LMS/RLS DTC-nonlinearity calibration datapath.
// Clears LUTs, sweeps sync delay under LMS, keeps the minimum-|ERR| delay, converges, then runs RLS with a divergence guard.
module cali_rls_seq #(
    parameter int ERR_W      = 12,
    parameter int CLR_CYC    = 4,
    parameter int SETTLE_CYC = 256,
    parameter int MEAS_LOG2  = 8,
    parameter int LMS_CYC    = 4096,
    parameter int DIV_CNT    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [1:0]       PSEGS_CFG,
    input  logic [ERR_W-1:0] ERR,
    input  logic [ERR_W-2:0] ERR_TH,
    output logic             EN,
    output logic             CALI_MODE_RLS,
    output logic [2:0]       SYNC_DLY,
    output logic [1:0]       PSEGS,
    output logic             CALI_NRST,
    output logic             BUSY,
    output logic             LOCK,
    output logic             DIVERGED,
    output logic [2:0]       BEST_DLY
);
    localparam int ACC_W    = ERR_W + MEAS_LOG2;
    localparam int MEAS_CYC = 1 << MEAS_LOG2;
    localparam int MAX_A    = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
    localparam int MAX_B    = (MEAS_CYC > LMS_CYC) ? MEAS_CYC : LMS_CYC;
    localparam int MAX_CYC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);
    localparam int DIV_W    = $clog2(DIV_CNT + 1);

    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYC - 1);
    localparam logic [CNT_W-1:0] LMS_LAST    = CNT_W'(LMS_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV_CNT - 1);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CLR1    = 4'd1;
    localparam logic [3:0] ST_SETTLE  = 4'd2;
    localparam logic [3:0] ST_MEAS    = 4'd3;
    localparam logic [3:0] ST_NEXT    = 4'd4;
    localparam logic [3:0] ST_CLR2    = 4'd5;
    localparam logic [3:0] ST_LMS_RUN = 4'd6;
    localparam logic [3:0] ST_RLS_RUN = 4'd7;
    localparam logic [3:0] ST_HOLD    = 4'd8;

    // Magnitude of a two's-complement sample; the most negative code maps to 2**(ERR_W-1).
    function automatic logic [ERR_W-1:0] abs_err(input logic [ERR_W-1:0] e);
        logic [ERR_W-1:0] r;
        if (e[ERR_W-1]) begin
            r = ~e + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            r = e;
        end
        return r;
    endfunction

    logic [3:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       d_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] best_acc_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [2:0]       best_dly_r;
    logic             diverged_r;
    logic [1:0]       psegs_r;
    logic [2:0]       sync_dly_r;
    logic             en_r;
    logic             rls_r;
    logic             nrst_r;
    logic             busy_r;
    logic             lock_r;

    logic [ERR_W-1:0] err_abs_s;
    logic             err_over_s;
    logic [3:0]       state_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [2:0]       d_nx_s;
    logic [ACC_W-1:0] acc_nx_s;
    logic [ACC_W-1:0] best_acc_nx_s;
    logic [DIV_W-1:0] div_cnt_nx_s;
    logic [2:0]       best_dly_nx_s;
    logic             diverged_nx_s;
    logic [1:0]       psegs_nx_s;
    logic [2:0]       sync_dly_nx_s;
    logic             en_nx_s;
    logic             rls_nx_s;
    logic             nrst_nx_s;
    logic             busy_nx_s;
    logic             lock_nx_s;

    assign err_abs_s  = abs_err(ERR);
    assign err_over_s = (err_abs_s > {1'b0, ERR_TH});

    // Sequencer next-state: phase counters, sweep bookkeeping and divergence watch.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        d_nx_s        = d_r;
        acc_nx_s      = acc_r;
        best_acc_nx_s = best_acc_r;
        div_cnt_nx_s  = div_cnt_r;
        best_dly_nx_s = best_dly_r;
        diverged_nx_s = diverged_r;
        psegs_nx_s    = psegs_r;
        sync_dly_nx_s = sync_dly_r;
        case (state_r)
            ST_IDLE, ST_HOLD: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (START) begin
                    state_nx_s    = ST_CLR1;
                    psegs_nx_s    = PSEGS_CFG;
                    diverged_nx_s = 1'b0;
                    d_nx_s        = 3'd0;
                    acc_nx_s      = {ACC_W{1'b0}};
                    div_cnt_nx_s  = {DIV_W{1'b0}};
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_CLR1: begin
                if (cnt_r == CLR_LAST) begin
                    state_nx_s    = ST_SETTLE;
                    cnt_nx_s      = {CNT_W{1'b0}};
                    sync_dly_nx_s = d_r;
                end else begin
                    state_nx_s = ST_CLR1;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nx_s = ST_MEAS;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    acc_nx_s   = {ACC_W{1'b0}};
                end else begin
                    state_nx_s = ST_SETTLE;
                end
            end
            ST_MEAS: begin
                acc_nx_s = acc_r + ACC_W'(err_abs_s);
                if (cnt_r == MEAS_LAST) begin
                    state_nx_s = ST_NEXT;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_MEAS;
                end
            end
            ST_NEXT: begin
                cnt_nx_s = {CNT_W{1'b0}};
                // Strict less-than: on a tie the earlier (lower) delay wins.
                if ((d_r == 3'd0) || (acc_r < best_acc_r)) begin
                    best_acc_nx_s = acc_r;
                    best_dly_nx_s = d_r;
                end else begin
                    best_acc_nx_s = best_acc_r;
                end
                if (d_r == 3'd7) begin
                    state_nx_s = ST_CLR2;
                end else begin
                    state_nx_s = ST_CLR1;
                    d_nx_s     = d_r + 3'd1;
                end
            end
            ST_CLR2: begin
                if (cnt_r == CLR_LAST) begin
                    state_nx_s    = ST_LMS_RUN;
                    cnt_nx_s      = {CNT_W{1'b0}};
                    sync_dly_nx_s = best_dly_r;
                end else begin
                    state_nx_s = ST_CLR2;
                end
            end
            ST_LMS_RUN: begin
                if (cnt_r == LMS_LAST) begin
                    state_nx_s   = ST_RLS_RUN;
                    cnt_nx_s     = {CNT_W{1'b0}};
                    div_cnt_nx_s = {DIV_W{1'b0}};
                end else begin
                    state_nx_s = ST_LMS_RUN;
                end
            end
            ST_RLS_RUN: begin
                cnt_nx_s = cnt_r;
                if (err_over_s) begin
                    if (div_cnt_r == DIV_LAST) begin
                        state_nx_s    = ST_HOLD;
                        diverged_nx_s = 1'b1;
                        div_cnt_nx_s  = {DIV_W{1'b0}};
                    end else begin
                        div_cnt_nx_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    div_cnt_nx_s = {DIV_W{1'b0}};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode of the upcoming state so registered outputs track the state register.
    always_comb begin
        en_nx_s   = 1'b0;
        rls_nx_s  = 1'b0;
        nrst_nx_s = 1'b1;
        busy_nx_s = 1'b0;
        lock_nx_s = 1'b0;
        case (state_nx_s)
            ST_IDLE: begin
                en_nx_s = 1'b0;
            end
            ST_CLR1, ST_CLR2: begin
                nrst_nx_s = 1'b0;
                busy_nx_s = 1'b1;
            end
            ST_SETTLE, ST_MEAS, ST_NEXT, ST_LMS_RUN: begin
                en_nx_s   = 1'b1;
                busy_nx_s = 1'b1;
            end
            ST_RLS_RUN: begin
                en_nx_s   = 1'b1;
                rls_nx_s  = 1'b1;
                busy_nx_s = 1'b1;
                lock_nx_s = 1'b1;
            end
            ST_HOLD: begin
                en_nx_s = 1'b1;
            end
            default: begin
                en_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers; ABORT keeps the selected delay and divergence flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            d_r        <= 3'd0;
            acc_r      <= {ACC_W{1'b0}};
            best_acc_r <= {ACC_W{1'b0}};
            div_cnt_r  <= {DIV_W{1'b0}};
            best_dly_r <= 3'd0;
            diverged_r <= 1'b0;
            psegs_r    <= 2'd0;
            sync_dly_r <= 3'd0;
            en_r       <= 1'b0;
            rls_r      <= 1'b0;
            nrst_r     <= 1'b1;
            busy_r     <= 1'b0;
            lock_r     <= 1'b0;
        end else if (ABORT) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            d_r        <= 3'd0;
            acc_r      <= {ACC_W{1'b0}};
            div_cnt_r  <= {DIV_W{1'b0}};
            en_r       <= 1'b0;
            rls_r      <= 1'b0;
            nrst_r     <= 1'b1;
            busy_r     <= 1'b0;
            lock_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            d_r        <= d_nx_s;
            acc_r      <= acc_nx_s;
            best_acc_r <= best_acc_nx_s;
            div_cnt_r  <= div_cnt_nx_s;
            best_dly_r <= best_dly_nx_s;
            diverged_r <= diverged_nx_s;
            psegs_r    <= psegs_nx_s;
            sync_dly_r <= sync_dly_nx_s;
            en_r       <= en_nx_s;
            rls_r      <= rls_nx_s;
            nrst_r     <= nrst_nx_s;
            busy_r     <= busy_nx_s;
            lock_r     <= lock_nx_s;
        end
    end

    assign EN            = en_r;
    assign CALI_MODE_RLS = rls_r;
    assign SYNC_DLY      = sync_dly_r;
    assign PSEGS         = psegs_r;
    assign CALI_NRST     = nrst_r;
    assign BUSY          = busy_r;
    assign LOCK          = lock_r;
    assign DIVERGED      = diverged_r;
    assign BEST_DLY      = best_dly_r;

endmodule
